// File: rtl/blackjack_ui_pkg.sv
// rtl/blackjack_ui_pkg.sv - shared command type, button indices and hit regions for the click decoder
package blackjack_ui_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_DEAL  = 2'd1,
        CMD_HIT   = 2'd2,
        CMD_STAND = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_LOCKOUT
    } state_t;

    localparam int BTN_DEAL  = 0;
    localparam int BTN_HIT   = 1;
    localparam int BTN_STAND = 2;

    localparam logic [11:0] DEAL_X0  = 12'd100;
    localparam logic [11:0] DEAL_X1  = 12'd229;
    localparam logic [11:0] HIT_X0   = 12'd300;
    localparam logic [11:0] HIT_X1   = 12'd429;
    localparam logic [11:0] STAND_X0 = 12'd500;
    localparam logic [11:0] STAND_X1 = 12'd629;
    localparam logic [11:0] BTN_Y0   = 12'd650;
    localparam logic [11:0] BTN_Y1   = 12'd699;

    // Overlap resolution: DEAL wins over HIT, HIT over STAND.
    function automatic logic [2:0] pick_hover(input logic [2:0] hit);
        if (hit[BTN_DEAL])       return 3'b001;
        else if (hit[BTN_HIT])   return 3'b010;
        else if (hit[BTN_STAND]) return 3'b100;
        else                     return 3'b000;
    endfunction

    function automatic cmd_t hover_to_cmd(input logic [2:0] h);
        if (h[BTN_DEAL])       return CMD_DEAL;
        else if (h[BTN_HIT])   return CMD_HIT;
        else if (h[BTN_STAND]) return CMD_STAND;
        else                   return CMD_NONE;
    endfunction

endpackage

// File: rtl/button_hit_test.sv
// rtl/button_hit_test.sv - combinational inclusive-bounds hit test for one enabled button region
module button_hit_test #(
    parameter logic [11:0] X0 = 12'd1,
    parameter logic [11:0] X1 = 12'd1,
    parameter logic [11:0] Y0 = 12'd1,
    parameter logic [11:0] Y1 = 12'd1
) (
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        enable,
    output logic        hit
);

    assign hit = enable && (xpos >= X0) && (xpos <= X1) && (ypos >= Y0) && (ypos <= Y1);

endmodule

// File: rtl/button_click_decoder.sv
// rtl/button_click_decoder.sv - click-to-command decoder with hold/handshake; CLICK_LOCKOUT_EN adds post-command lockout
module button_click_decoder
    import blackjack_ui_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = 6_500_000,
    parameter int CNT_W          = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        click,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [2:0]  btn_enable,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output cmd_t        cmd,
    output logic [2:0]  hover,
    output logic [7:0]  drop_cnt
);

    if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES >= (2 ** CNT_W)) begin : g_bad_cfg
        $error("CNT_W too narrow for LOCKOUT_CYCLES");
    end

    // Assertion is asynchronous; release passes two flops before the FSM sees it.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= rst_sync_d;
    end

    assign rst_int_n = rst_sync_q[1];

    logic [2:0] hit;

    button_hit_test #(.X0(DEAL_X0), .X1(DEAL_X1), .Y0(BTN_Y0), .Y1(BTN_Y1)) u_hit_deal (
        .xpos(xpos), .ypos(ypos), .enable(btn_enable[BTN_DEAL]), .hit(hit[BTN_DEAL])
    );
    button_hit_test #(.X0(HIT_X0), .X1(HIT_X1), .Y0(BTN_Y0), .Y1(BTN_Y1)) u_hit_hit (
        .xpos(xpos), .ypos(ypos), .enable(btn_enable[BTN_HIT]), .hit(hit[BTN_HIT])
    );
    button_hit_test #(.X0(STAND_X0), .X1(STAND_X1), .Y0(BTN_Y0), .Y1(BTN_Y1)) u_hit_stand (
        .xpos(xpos), .ypos(ypos), .enable(btn_enable[BTN_STAND]), .hit(hit[BTN_STAND])
    );

    state_t     state_q, state_d;
    cmd_t       cmd_q, cmd_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [2:0] hover_q, hover_d;
    logic [7:0] drop_q, drop_d;
`ifdef CLICK_LOCKOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        hover_d     = pick_hover(hit);
        drop_d      = drop_q;
`ifdef CLICK_LOCKOUT_EN
        cnt_d       = cnt_q;
`endif
        if (click && state_q != ST_IDLE && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
        case (state_q)
            ST_IDLE: begin
                if (click && hover_d != 3'b000) begin
                    cmd_d       = hover_to_cmd(hover_d);
                    cmd_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cmd_ready) begin
                    cmd_d       = CMD_NONE;
                    cmd_valid_d = 1'b0;
`ifdef CLICK_LOCKOUT_EN
                    state_d     = ST_LOCKOUT;
                    cnt_d       = CNT_W'(LOCKOUT_CYCLES - 1);
`else
                    state_d     = ST_IDLE;
`endif
                end
            end
`ifdef CLICK_LOCKOUT_EN
            ST_LOCKOUT: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_NONE;
            cmd_valid_q <= 1'b0;
            hover_q     <= 3'b000;
            drop_q      <= 8'd0;
`ifdef CLICK_LOCKOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            hover_q     <= hover_d;
            drop_q      <= drop_d;
`ifdef CLICK_LOCKOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign hover     = hover_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_button_click_decoder.sv
// tb/tb_button_click_decoder.sv - self-checking bench for button_click_decoder (directed scenarios plus random vs model)
module tb_button_click_decoder;

`ifdef CLICK_LOCKOUT_EN
    localparam int LOCK = 4;
`else
    localparam int LOCK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        click = 1'b0;
    logic [11:0] xpos = '0;
    logic [11:0] ypos = '0;
    logic [2:0]  btn_enable = 3'b111;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic [2:0]  hover;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: pending command code, remaining lockout cycles, drop total, hover.
    int m_pending, m_lock, m_drops, m_hover;

    button_click_decoder #(.LOCKOUT_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .click(click), .xpos(xpos), .ypos(ypos),
        .btn_enable(btn_enable), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid),
        .cmd(cmd), .hover(hover), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic int region_code(input int x, input int y, input logic [2:0] en);
        for (int b = 0; b < 3; b++) begin
            if (en[b] && x >= 100 + 200 * b && x <= 229 + 200 * b && y >= 650 && y <= 699)
                return b + 1;
        end
        return 0;
    endfunction

    task automatic model_step();
        int code;
        code    = region_code(int'(xpos), int'(ypos), btn_enable);
        m_hover = (code == 0) ? 0 : (1 << (code - 1));
        if (m_pending != 0) begin
            if (click && m_drops < 255) m_drops++;
            if (cmd_ready) begin
                m_pending = 0;
                m_lock    = LOCK;
            end
        end else if (m_lock > 0) begin
            if (click && m_drops < 255) m_drops++;
            m_lock--;
        end else if (click && code != 0) begin
            m_pending = code;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; click = 1'b0; cmd_ready = 1'b0;
        xpos = '0; ypos = '0; btn_enable = 3'b111;
        m_pending = 0; m_lock = 0; m_drops = 0; m_hover = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", cmd_valid); end
        checks++; if (cmd !== 2'd0) begin errors++; $display("FAIL reset_cmd got %0d want 0", cmd); end
        checks++; if (hover !== 3'b000) begin errors++; $display("FAIL reset_hover got %b want 000", hover); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    endtask

    task automatic test_deal();
        do_reset();
        cmd_ready = 1'b1; xpos = 12'd150; ypos = 12'd675; click = 1'b1;
        tick();
        click = 1'b0;
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL deal_valid got %0b want 1", cmd_valid); end
        checks++; if (cmd !== 2'd1) begin errors++; $display("FAIL deal_cmd got %0d want 1", cmd); end
        checks++; if (hover !== 3'b001) begin errors++; $display("FAIL deal_hover got %b want 001", hover); end
        tick();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL deal_one_cycle got %0b want 0", cmd_valid); end
        checks++; if (cmd !== 2'd0) begin errors++; $display("FAIL deal_cmd_none got %0d want 0", cmd); end
        repeat (LOCK + 1) tick();
    endtask

    task automatic test_bounds();
        int tx[6] = '{429, 430, 150, 100, 629, 99};
        int ty[6] = '{699, 699, 700, 650, 699, 650};
        int tc[6] = '{2, 0, 0, 1, 3, 0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            xpos = 12'(tx[i]); ypos = 12'(ty[i]); cmd_ready = 1'b1; click = 1'b1;
            tick();
            click = 1'b0;
            checks++; if (cmd_valid !== (tc[i] != 0)) begin errors++; $display("FAIL bounds_valid(%0d,%0d) got %0b want %0b", tx[i], ty[i], cmd_valid, tc[i] != 0); end
            checks++; if (cmd !== 2'(tc[i])) begin errors++; $display("FAIL bounds_cmd(%0d,%0d) got %0d want %0d", tx[i], ty[i], cmd, tc[i]); end
            repeat (LOCK + 2) tick();
        end
    endtask

    task automatic test_disabled();
        do_reset();
        btn_enable = 3'b001; xpos = 12'd350; ypos = 12'd675; cmd_ready = 1'b1; click = 1'b1;
        tick();
        click = 1'b0;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL disabled_valid got %0b want 0", cmd_valid); end
        checks++; if (hover !== 3'b000) begin errors++; $display("FAIL disabled_hover got %b want 000", hover); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL disabled_drop got %0d want 0", drop_cnt); end
        btn_enable = 3'b111;
        tick();
        checks++; if (hover !== 3'b010) begin errors++; $display("FAIL enabled_hover got %b want 010", hover); end
    endtask

    task automatic test_hold_drop();
        int hs;
        do_reset();
        cmd_ready = 1'b0; xpos = 12'd550; ypos = 12'd675; click = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            click = (i == 2 || i == 5 || i == 7);
            btn_enable = 3'($urandom);
            tick();
            checks++; if ({cmd_valid, cmd} !== 3'b111) begin errors++; $display("FAIL hold_stable[%0d] got %0b/%0d want 1/3", i, cmd_valid, cmd); end
        end
        click = 1'b0;
        checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL hold_drop got %0d want 3", drop_cnt); end
        cmd_ready = 1'b1; click = 1'b1; hs = 0;
        for (int i = 0; i < 4; i++) begin
            if (cmd_valid && cmd_ready) hs++;
            tick();
            click = 1'b0;
        end
        checks++; if (hs !== 1) begin errors++; $display("FAIL hold_handshakes got %0d want 1", hs); end
        checks++; if (drop_cnt !== 8'd4) begin errors++; $display("FAIL handshake_click_drop got %0d want 4", drop_cnt); end
        btn_enable = 3'b111;
        repeat (LOCK + 1) tick();
    endtask

    task automatic test_lockout();
        do_reset();
        xpos = 12'd150; ypos = 12'd675; cmd_ready = 1'b0; click = 1'b1;
        tick();
        click = 1'b0; cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        for (int k = 1; k <= LOCK + 1; k++) begin
            click = 1'b1;
            tick();
            click = 1'b0;
            checks++; if (cmd_valid !== (k == LOCK + 1)) begin errors++; $display("FAIL lockout_click_at_+%0d got %0b want %0b", k, cmd_valid, k == LOCK + 1); end
        end
        checks++; if (drop_cnt !== 8'(LOCK)) begin errors++; $display("FAIL lockout_drop got %0d want %0d", drop_cnt, LOCK); end
        cmd_ready = 1'b1;
        tick();
        repeat (LOCK + 1) tick();
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        xpos = 12'd550; ypos = 12'd675; cmd_ready = 1'b0; click = 1'b1;
        tick();
        tick();
        click = 1'b0;
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL prereset_drop got %0d want 1", drop_cnt); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid got %0b want 0", cmd_valid); end
        checks++; if (cmd !== 2'd0) begin errors++; $display("FAIL async_reset_cmd got %0d want 0", cmd); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL async_reset_drop got %0d want 0", drop_cnt); end
        m_pending = 0; m_lock = 0; m_drops = 0; m_hover = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL postreset_valid got %0b want 0", cmd_valid); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL postreset_drop got %0d want 0", drop_cnt); end
        xpos = 12'd150; click = 1'b1;
        tick();
        click = 1'b0;
        checks++; if ({cmd_valid, cmd} !== 3'b101) begin errors++; $display("FAIL postreset_accept got %0b/%0d want 1/1", cmd_valid, cmd); end
    endtask

    task automatic test_saturate();
        do_reset();
        xpos = 12'd550; ypos = 12'd675; cmd_ready = 1'b0; click = 1'b1;
        repeat (262) tick();
        click = 1'b0;
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_saturate got %0d want 255", drop_cnt); end
        cmd_ready = 1'b1;
        tick();
        repeat (LOCK + 1) tick();
    endtask

    task automatic test_random();
        int b;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            b = $urandom_range(0, 2);
            btn_enable = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            xpos = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 700))
                                               : 12'(99 + 200 * b + $urandom_range(0, 131));
            ypos = 12'($urandom_range(645, 704));
            click = ($urandom_range(0, 3) == 0);
            cmd_ready = ($urandom_range(0, 2) == 0);
            tick();
            checks++; if (cmd_valid !== (m_pending != 0)) begin errors++; $display("FAIL rand_valid[%0d] got %0b want %0b", i, cmd_valid, m_pending != 0); end
            checks++; if (cmd !== 2'(m_pending)) begin errors++; $display("FAIL rand_cmd[%0d] got %0d want %0d", i, cmd, m_pending); end
            checks++; if (hover !== 3'(m_hover)) begin errors++; $display("FAIL rand_hover[%0d] got %b want %b", i, hover, 3'(m_hover)); end
            checks++; if (drop_cnt !== 8'(m_drops)) begin errors++; $display("FAIL rand_drop[%0d] got %0d want %0d", i, drop_cnt, m_drops); end
        end
    endtask

    initial begin
        test_reset();
        test_deal();
        test_bounds();
        test_disabled();
        test_hold_drop();
        test_lockout();
        test_reset_mid_hold();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_click_decoder.md
BUTTON_CLICK_DECODER -- requirements
Module: button_click_decoder

Interface
REQ-001 Parameter LOCKOUT_CYCLES, default 6_500_000, is the post-command click-ignore window in clk cycles (100 ms at 65 MHz).
REQ-002 Parameter CNT_W, default 23, is the lockout counter width and SHALL hold LOCKOUT_CYCLES.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 click  input  1  one-cycle click pulse from the upstream click edge filter.
REQ-006 xpos  input  12  cursor x, pixels, valid every cycle.
REQ-007 ypos  input  12  cursor y, pixels, valid every cycle.
REQ-008 btn_enable  input  3  per-button enable from the game FSM: [0] DEAL, [1] HIT, [2] STAND.
REQ-009 cmd_ready  input  1  game FSM accepts the command.
REQ-010 cmd_valid  output  1  command pending.
REQ-011 cmd  output  2  command code, type cmd_t: NONE=0, DEAL=1, HIT=2, STAND=3.
REQ-012 hover  output  3  one-hot enabled button under the cursor, for highlight rendering.
REQ-013 drop_cnt  output  8  saturating count of clicks discarded while busy.

Function
REQ-014 Hit-test SHALL use inclusive bounds, x0<=xpos<=x1 and y0<=ypos<=y1, with region constants from the package.
REQ-015 A region SHALL count as hit only if its btn_enable bit is 1.
REQ-016 On overlapping regions, priority SHALL be DEAL > HIT > STAND.
REQ-017 FSM states SHALL be IDLE, HOLD and LOCKOUT.
REQ-018 In IDLE, click=1 with an enabled region hit at cycle N SHALL latch cmd and set cmd_valid=1 from cycle N+1, state HOLD.
REQ-019 In IDLE, a click with no enabled region hit SHALL be ignored, with no drop_cnt change.
REQ-020 In HOLD, cmd_valid and cmd SHALL stay stable until cmd_valid&&cmd_ready.
REQ-021 The handshake cycle SHALL be the last cycle of cmd_valid=1; cmd SHALL return to NONE on the next cycle.
REQ-022 After the handshake the next state SHALL be LOCKOUT, counter loaded with LOCKOUT_CYCLES-1.
REQ-023 LOCKOUT SHALL decrement the counter each cycle and go to IDLE when it reaches 0.
REQ-024 Any click in HOLD or LOCKOUT, including one in the handshake cycle, SHALL be discarded and SHALL increment drop_cnt, saturating at 255.
REQ-025 btn_enable changes during HOLD SHALL NOT cancel or alter the pending command.
REQ-026 hover SHALL be registered, reflecting xpos/ypos/btn_enable of the previous cycle, in every state.
REQ-027 cmd_ready while cmd_valid=0 SHALL have no effect.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, cmd_valid=0, cmd=NONE, hover=0, drop_cnt=0 and lockout counter=0.
REQ-029 Reset asserted mid-HOLD or mid-LOCKOUT SHALL discard the pending command or lockout.
REQ-030 Release of reset SHALL be synchronized to clk before it reaches the FSM.

Configuration
REQ-031 Macro CLICK_LOCKOUT_EN defined: LOCKOUT state is implemented per REQ-022/023.
REQ-032 Macro CLICK_LOCKOUT_EN undefined: no counter logic; the handshake returns directly to IDLE, and the first click accepted is at cycle handshake+1.

Structure
REQ-033 Package blackjack_ui_pkg SHALL hold cmd_t, the button index constants and the region bounds: DEAL x100..229, HIT x300..429, STAND x500..629, all y650..699.
REQ-034 Sub-module button_hit_test (combinational, one region, parameterized bounds) SHALL be instantiated three times; the FSM, counter and registers stay in the top module.

Verification
REQ-035 btn_enable=3'b111, click at (150,675), cmd_ready=1 -> cmd_valid=1 with cmd=DEAL one cycle later, for exactly one cycle.
REQ-036 Click at (429,699) -> HIT; click at (430,699) and click at (150,700) -> no command.
REQ-037 btn_enable=3'b001, click at (350,675) -> no command; hover=3'b000 when the cursor is over HIT.
REQ-038 cmd_ready=0 for 10 cycles after a STAND click -> cmd_valid stays 1 and cmd stays 3; three more clicks -> drop_cnt=3; cmd_ready=1 -> single handshake.
REQ-039 With CLICK_LOCKOUT_EN and LOCKOUT_CYCLES=4 -> clicks at handshake+1..+4 dropped, click at +5 accepted; without the macro -> click at +1 accepted.
REQ-040 rst_n pulled low while HOLD -> cmd_valid=0 with no clk edge; after release, IDLE and drop_cnt=0.
